// File: rtl/ptr_sync_gray2bin_pkg.sv
// Shared defaults and Gray-pointer helpers for the pointer synchronizers,
// the flag logic and the pointer counters.
package ptr_sync_gray2bin_pkg;

  localparam int unsigned A_LENGTH_DEF    = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned FN_W            = 32;

  // Leading zeros above the real pointer width do not disturb the conversion.
  function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] g);
    logic [FN_W-1:0] b;
    b[FN_W-1] = g[FN_W-1];
    for (int i = FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(input logic [FN_W-1:0] x);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < FN_W; i++) begin
      c = c + 6'(x[i]);
    end
    return c;
  endfunction

  function automatic logic dist_gt1(input logic [FN_W-1:0] a, input logic [FN_W-1:0] b);
    return popcount(a ^ b) > 6'd1;
  endfunction

endpackage

// File: rtl/ptr_sync_gray2bin_sync_chain.sv
// WIDTH x STAGES flop chain with synchronous reset; no logic between stages.
module ptr_sync_gray2bin_sync_chain
  import ptr_sync_gray2bin_pkg::*;
#(
  parameter int unsigned WIDTH  = A_LENGTH_DEF + 1,
  parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray2bin.sv
// Synchronizes a far-domain Gray pointer, rejects multi-bit jumps, and
// presents the accepted value as a registered binary pointer plus wrap bit.
module ptr_sync_gray2bin
  import ptr_sync_gray2bin_pkg::*;
#(
  parameter int unsigned A_LENGTH    = A_LENGTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [A_LENGTH:0]   gray_ptr_in,
  input  logic                err_clr,
  output logic [A_LENGTH-1:0] b_ptr_sync,
  output logic                MSB_ptr,
  output logic                ptr_valid,
  output logic                f_sync_err
);

  localparam int unsigned PTR_W = A_LENGTH + 1;
  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] FILL_THR = CNT_W'(SYNC_STAGES);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
    $error("SYNC_STAGES must be in 2..4");
  end

  logic [PTR_W-1:0] g;
  logic [PTR_W-1:0] acc;
  logic [PTR_W-1:0] bin;
  logic [CNT_W-1:0] fill_cnt;
  logic             step_ok;
  logic             jump_err;

  ptr_sync_gray2bin_sync_chain #(
    .WIDTH (PTR_W),
    .STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk  (clk),
    .reset(reset),
    .d    (gray_ptr_in),
    .q    (g)
  );

  // Classify the synchronized sample against the last accepted one.
  always_comb begin
    jump_err = dist_gt1(FN_W'(g), FN_W'(acc));
    step_ok  = (g != acc) && !jump_err;
    bin      = PTR_W'(gray2bin(FN_W'(g)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      b_ptr_sync <= '0;
      MSB_ptr    <= 1'b0;
      f_sync_err <= 1'b0;
      fill_cnt   <= '0;
      ptr_valid  <= 1'b0;
    end else begin
      if (step_ok) begin
        acc        <= g;
        b_ptr_sync <= bin[A_LENGTH-1:0];
        MSB_ptr    <= bin[A_LENGTH];
      end
      // A fresh error outranks a simultaneous clear.
      if (jump_err) begin
        f_sync_err <= 1'b1;
      end else if (err_clr) begin
        f_sync_err <= 1'b0;
      end
      if (fill_cnt != FILL_MAX) begin
        fill_cnt <= fill_cnt + CNT_W'(1);
      end
      if (fill_cnt >= FILL_THR) begin
        ptr_valid <= 1'b1;
      end
    end
  end

endmodule
